// File: rtl/ps_lane_scheduler_pkg.sv
// Shared symbol constants and encodings for the 10-bit transmit lane scheduler.
package ps_lane_pkg;

  localparam logic [9:0] SYM_COM = 10'b0011111010;  // K28.5, RD-
  localparam logic [9:0] SYM_SKP = 10'b0011110100;  // K28.0
  localparam logic [9:0] SYM_IDL = 10'b0011110011;  // K28.3

  typedef enum logic [1:0] {
    SRC_DATA = 2'd0,
    SRC_IDLE = 2'd1,
    SRC_COM  = 2'd2,
    SRC_SKP  = 2'd3
  } sym_src_t;

  typedef enum logic [1:0] {
    TRAIN = 2'd0,
    DATA  = 2'd1,
    SKIP  = 2'd2
  } lane_state_t;

endpackage

// File: rtl/ps_lane_scheduler_rr_arbiter.sv
// Round-robin grant over N_REQ requesters; the pointer moves to the winner on advance.
module ps_rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant,
  output logic [2:0]       grant_id,
  output logic             any
);

  logic [2:0] ptr;
  logic [3:0] idx;

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    grant    = '0;
    grant_id = ptr;
    any      = 1'b0;
    idx      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(N_REQ)) idx = idx - 4'(N_REQ);
      for (int j = 0; j < N_REQ; j++) begin
        if (!any && idx == 4'(j) && req[j]) begin
          any      = 1'b1;
          grant[j] = 1'b1;
          grant_id = 3'(j);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ptr <= 3'(N_REQ - 1);
    else if (advance && any) ptr <= grant_id;
  end

endmodule

// File: rtl/ps_lane_scheduler.sv
// Transmit lane controller: symbol load strobe, training preamble, SKP insertion and RR arbitration.
module ps_lane_scheduler
  import ps_lane_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int TRAIN_LEN    = 16,
  parameter int SKP_INTERVAL = 118,
  parameter int SKP_COUNT    = 3
) (
  input  logic                 CLOCK,
  input  logic                 RESET_L,
  input  logic [N_REQ-1:0]     REQ_VALID,
  input  logic [10*N_REQ-1:0]  REQ_DATA,
  output logic [N_REQ-1:0]     REQ_READY,
  output logic                 LOAD,
  output logic [9:0]           SYM_OUT,
  output logic [2:0]           GRANT_ID,
  output logic [1:0]           SYM_SRC,
  output logic                 LINK_UP
);

  logic [3:0]  slot_cnt, slot_cnt_d;
  lane_state_t state_q, state_d;
  logic [7:0]  train_cnt, train_cnt_d;
  logic [9:0]  skip_cnt, skip_cnt_d;
  logic [2:0]  skp_cnt, skp_cnt_d;
  logic        vld_p0, vld_d;
  logic [9:0]  sym_p0, sym_d;
  sym_src_t    src_p0, src_d;
  logic [2:0]  gid_p0, gid_d;
  logic        link_p0, link_d;

  logic             slot_edge, skip_due, data_slot;
  logic [N_REQ-1:0] win_grant;
  logic [2:0]       win_id;
  logic             win_any;
  logic [9:0]       win_data;

  assign slot_edge = (slot_cnt == 4'd9);
  assign skip_due  = (state_q == DATA) && (skip_cnt == 10'(SKP_INTERVAL));
  assign data_slot = slot_edge && (state_q == DATA) && !skip_due;
  assign REQ_READY = win_grant & {N_REQ{data_slot}};

  ps_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk      (CLOCK),
    .rst_n    (RESET_L),
    .req      (REQ_VALID),
    .advance  (data_slot),
    .grant    (win_grant),
    .grant_id (win_id),
    .any      (win_any)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (win_grant[i]) win_data = REQ_DATA[10*i +: 10];
  end

  always_comb begin
    state_d     = state_q;
    train_cnt_d = train_cnt;
    skip_cnt_d  = skip_cnt;
    skp_cnt_d   = skp_cnt;
    sym_d       = sym_p0;
    src_d       = src_p0;
    gid_d       = gid_p0;
    link_d      = link_p0;
    vld_d       = 1'b0;
    slot_cnt_d  = slot_edge ? 4'd0 : slot_cnt + 4'd1;
    if (slot_edge) begin
      vld_d = 1'b1;
      case (state_q)
        TRAIN: begin
          sym_d = SYM_COM;
          src_d = SRC_COM;
          if (train_cnt == 8'(TRAIN_LEN - 1)) begin
            link_d  = 1'b1;
            state_d = DATA;
          end else begin
            train_cnt_d = train_cnt + 8'd1;
          end
        end
        DATA: begin
          if (skip_due) begin
            sym_d      = SYM_COM;
            src_d      = SRC_COM;
            state_d    = SKIP;
            skip_cnt_d = '0;
            skp_cnt_d  = '0;
          end else begin
            skip_cnt_d = skip_cnt + 10'd1;
            if (win_any) begin
              sym_d = win_data;
              src_d = SRC_DATA;
              gid_d = win_id;
            end else begin
              sym_d = SYM_IDL;
              src_d = SRC_IDLE;
            end
          end
        end
        SKIP: begin
          sym_d = SYM_SKP;
          src_d = SRC_SKP;
          if (skp_cnt == 3'(SKP_COUNT - 1)) state_d = DATA;
          else                               skp_cnt_d = skp_cnt + 3'd1;
        end
        default: state_d = TRAIN;
      endcase
    end
  end

  // Output stage: everything the serializer sees changes only on the slot edge.
  always_ff @(posedge CLOCK or negedge RESET_L) begin
    if (!RESET_L) begin
      slot_cnt  <= '0;
      state_q   <= TRAIN;
      train_cnt <= '0;
      skip_cnt  <= '0;
      skp_cnt   <= '0;
      vld_p0    <= 1'b0;
      sym_p0    <= '0;
      src_p0    <= SRC_DATA;
      gid_p0    <= '0;
      link_p0   <= 1'b0;
    end else begin
      slot_cnt  <= slot_cnt_d;
      state_q   <= state_d;
      train_cnt <= train_cnt_d;
      skip_cnt  <= skip_cnt_d;
      skp_cnt   <= skp_cnt_d;
      vld_p0    <= vld_d;
      sym_p0    <= sym_d;
      src_p0    <= src_d;
      gid_p0    <= gid_d;
      link_p0   <= link_d;
    end
  end

  assign LOAD     = vld_p0;
  assign SYM_OUT  = sym_p0;
  assign SYM_SRC  = src_p0;
  assign GRANT_ID = gid_p0;
  assign LINK_UP  = link_p0;

endmodule

// File: tb/tb_ps_lane_scheduler.sv
// Directed bench for ps_lane_scheduler with N_REQ=3, TRAIN_LEN=4, SKP_INTERVAL=5, SKP_COUNT=3.
module tb_ps_lane_scheduler;

  localparam int N_REQ = 3;

  logic              CLOCK = 1'b0;
  logic              RESET_L;
  logic [N_REQ-1:0]  REQ_VALID;
  logic [10*N_REQ-1:0] REQ_DATA;
  logic [N_REQ-1:0]  REQ_READY;
  logic              LOAD;
  logic [9:0]        SYM_OUT;
  logic [2:0]        GRANT_ID;
  logic [1:0]        SYM_SRC;
  logic              LINK_UP;

  int checks = 0;
  int errors = 0;

  int               rdy_cycles;
  logic [N_REQ-1:0] rdy_last;
  logic             got_load;
  int               gap;

  always #5 CLOCK = ~CLOCK;

  ps_lane_scheduler #(
    .N_REQ(N_REQ), .TRAIN_LEN(4), .SKP_INTERVAL(5), .SKP_COUNT(3)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET_L   (RESET_L),
    .REQ_VALID (REQ_VALID),
    .REQ_DATA  (REQ_DATA),
    .REQ_READY (REQ_READY),
    .LOAD      (LOAD),
    .SYM_OUT   (SYM_OUT),
    .GRANT_ID  (GRANT_ID),
    .SYM_SRC   (SYM_SRC),
    .LINK_UP   (LINK_UP)
  );

  // Advance to the next LOAD, recording REQ_READY activity in the slot that precedes it.
  task automatic next_slot();
    rdy_cycles = 0;
    rdy_last   = '0;
    got_load   = 1'b0;
    gap        = 0;
    for (int i = 0; i < 12 && !got_load; i++) begin
      @(negedge CLOCK);
      gap++;
      if (LOAD) got_load = 1'b1;
      else if (REQ_READY != '0) begin
        rdy_cycles++;
        rdy_last = REQ_READY;
      end
    end
    checks++;
    if (!got_load) begin
      errors++;
      $display("FAIL load_timeout: got no LOAD, required one within 12 cycles");
    end
  endtask

  task automatic do_reset();
    RESET_L   = 1'b0;
    REQ_VALID = '0;
    REQ_DATA  = '0;
    repeat (3) @(negedge CLOCK);
    RESET_L = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    RESET_L   = 1'b0;
    REQ_VALID = '0;
    REQ_DATA  = '0;
    repeat (3) @(negedge CLOCK);
    checks++;
    if ({LOAD, SYM_OUT, GRANT_ID, SYM_SRC, LINK_UP, REQ_READY} !== '0) begin
      errors++;
      $display("FAIL reset_state: got LOAD=%b SYM=%h GID=%0d SRC=%0d LU=%b RDY=%b, required all 0",
               LOAD, SYM_OUT, GRANT_ID, SYM_SRC, LINK_UP, REQ_READY);
    end
    RESET_L = 1'b1;
    n = 0;
    while (!LOAD && n < 20) begin
      @(negedge CLOCK);
      n++;
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL first_load_latency: got %0d cycles, required 10", n);
    end
    checks++;
    if (SYM_OUT !== 10'h0FA || SYM_SRC !== 2'd2 || LINK_UP !== 1'b0) begin
      errors++;
      $display("FAIL first_load_com: got SYM=%h SRC=%0d LU=%b, required 0fa 2 0", SYM_OUT, SYM_SRC, LINK_UP);
    end
  endtask

  task automatic test_training_idle_skip();
    logic [9:0] esym;
    logic [1:0] esrc;
    logic       elu;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      next_slot();
      if (i < 4)       begin esym = 10'h0FA; esrc = 2'd2; elu = (i == 3); end
      else if (i < 9)  begin esym = 10'h0F3; esrc = 2'd1; elu = 1'b1; end
      else if (i == 9) begin esym = 10'h0FA; esrc = 2'd2; elu = 1'b1; end
      else if (i < 13) begin esym = 10'h0F4; esrc = 2'd3; elu = 1'b1; end
      else             begin esym = 10'h0F3; esrc = 2'd1; elu = 1'b1; end
      checks++;
      if (SYM_OUT !== esym || SYM_SRC !== esrc || LINK_UP !== elu || GRANT_ID !== 3'd0) begin
        errors++;
        $display("FAIL idle_slot%0d: got SYM=%h SRC=%0d LU=%b GID=%0d, required %h %0d %b 0",
                 i, SYM_OUT, SYM_SRC, LINK_UP, GRANT_ID, esym, esrc, elu);
      end
      checks++;
      if ((i > 0 && gap != 10) || rdy_cycles != 0) begin
        errors++;
        $display("FAIL idle_spacing%0d: got gap=%0d ready_cycles=%0d, required 10 0", i, gap, rdy_cycles);
      end
    end
  endtask

  task automatic test_rotation();
    logic [9:0]       esym;
    logic [1:0]       esrc;
    logic [2:0]       egid;
    logic [N_REQ-1:0] erdy;
    do_reset();
    REQ_VALID = 3'b011;
    REQ_DATA  = {10'h000, 10'h2AA, 10'h155};
    for (int i = 0; i < 4; i++) begin
      next_slot();
      checks++;
      if (rdy_cycles != 0) begin
        errors++;
        $display("FAIL rot_train_ready%0d: got %0d ready cycles, required 0", i, rdy_cycles);
      end
    end
    for (int i = 0; i < 10; i++) begin
      next_slot();
      case (i)
        0, 2, 4: begin esym = 10'h155; esrc = 2'd0; egid = 3'd0; erdy = 3'b001; end
        1, 3, 9: begin esym = 10'h2AA; esrc = 2'd0; egid = 3'd1; erdy = 3'b010; end
        5:       begin esym = 10'h0FA; esrc = 2'd2; egid = 3'd0; erdy = 3'b000; end
        default: begin esym = 10'h0F4; esrc = 2'd3; egid = 3'd0; erdy = 3'b000; end
      endcase
      checks++;
      if (SYM_OUT !== esym || SYM_SRC !== esrc || GRANT_ID !== egid) begin
        errors++;
        $display("FAIL rot_slot%0d: got SYM=%h SRC=%0d GID=%0d, required %h %0d %0d",
                 i, SYM_OUT, SYM_SRC, GRANT_ID, esym, esrc, egid);
      end
      checks++;
      if (rdy_last !== erdy || rdy_cycles != ((erdy != 0) ? 1 : 0)) begin
        errors++;
        $display("FAIL rot_ready%0d: got %b x%0d, required %b", i, rdy_last, rdy_cycles, erdy);
      end
    end
  endtask

  // Continues from test_rotation: GRANT_ID=1 and LINK_UP=1 at this point.
  task automatic test_midreset();
    int n;
    repeat (4) @(posedge CLOCK);
    #2 RESET_L = 1'b0;
    #1;
    checks++;
    if ({LOAD, SYM_OUT, GRANT_ID, SYM_SRC, LINK_UP, REQ_READY} !== '0) begin
      errors++;
      $display("FAIL async_clear: got LOAD=%b SYM=%h GID=%0d SRC=%0d LU=%b RDY=%b, required all 0",
               LOAD, SYM_OUT, GRANT_ID, SYM_SRC, LINK_UP, REQ_READY);
    end
    @(negedge CLOCK);
    RESET_L = 1'b1;
    n = 0;
    while (!LOAD && n < 20) begin
      @(negedge CLOCK);
      n++;
    end
    checks++;
    if (n != 10 || SYM_OUT !== 10'h0FA || LINK_UP !== 1'b0) begin
      errors++;
      $display("FAIL retrain_first: got %0d cycles SYM=%h LU=%b, required 10 0fa 0", n, SYM_OUT, LINK_UP);
    end
    next_slot();
    next_slot();
    checks++;
    if (LINK_UP !== 1'b0 || SYM_OUT !== 10'h0FA) begin
      errors++;
      $display("FAIL retrain_third: got LU=%b SYM=%h, required 0 0fa", LINK_UP, SYM_OUT);
    end
    next_slot();
    checks++;
    if (LINK_UP !== 1'b1 || SYM_OUT !== 10'h0FA) begin
      errors++;
      $display("FAIL retrain_linkup: got LU=%b SYM=%h, required 1 0fa", LINK_UP, SYM_OUT);
    end
  endtask

  task automatic test_skip_wait();
    do_reset();
    REQ_DATA[19:10] = 10'h111;
    repeat (9) next_slot();
    REQ_VALID = 3'b010;
    next_slot();
    checks++;
    if (SYM_OUT !== 10'h0FA || SYM_SRC !== 2'd2 || rdy_cycles != 0) begin
      errors++;
      $display("FAIL skipwait_com: got SYM=%h SRC=%0d rdy=%0d, required 0fa 2 0", SYM_OUT, SYM_SRC, rdy_cycles);
    end
    for (int i = 0; i < 3; i++) begin
      next_slot();
      checks++;
      if (SYM_OUT !== 10'h0F4 || SYM_SRC !== 2'd3 || rdy_cycles != 0) begin
        errors++;
        $display("FAIL skipwait_skp%0d: got SYM=%h SRC=%0d rdy=%0d, required 0f4 3 0",
                 i, SYM_OUT, SYM_SRC, rdy_cycles);
      end
    end
    REQ_DATA[19:10] = 10'h1C7;
    next_slot();
    checks++;
    if (SYM_OUT !== 10'h1C7 || SYM_SRC !== 2'd0 || GRANT_ID !== 3'd1 || rdy_last !== 3'b010) begin
      errors++;
      $display("FAIL skipwait_data: got SYM=%h SRC=%0d GID=%0d RDY=%b, required 1c7 0 1 010",
               SYM_OUT, SYM_SRC, GRANT_ID, rdy_last);
    end
  endtask

  task automatic test_three_way();
    logic [9:0] esym;
    logic [2:0] egid;
    do_reset();
    REQ_DATA = {10'h3C3, 10'h000, 10'h0F0};
    repeat (4) next_slot();
    REQ_VALID = 3'b100;
    for (int i = 0; i < 4; i++) begin
      next_slot();
      REQ_VALID = 3'b101;
      egid = (i % 2 == 0) ? 3'd2 : 3'd0;
      esym = (i % 2 == 0) ? 10'h3C3 : 10'h0F0;
      checks++;
      if (SYM_OUT !== esym || GRANT_ID !== egid || SYM_SRC !== 2'd0 || rdy_last !== (3'b001 << egid)) begin
        errors++;
        $display("FAIL three_way%0d: got SYM=%h GID=%0d SRC=%0d RDY=%b, required %h %0d 0",
                 i, SYM_OUT, GRANT_ID, SYM_SRC, rdy_last, esym, egid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_training_idle_skip();
    test_rotation();
    test_midreset();
    test_skip_wait();
    test_three_way();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion");
    $fatal(1);
  end

endmodule
